// File: rtl/norm_pack.sv
// norm_pack: renormalize, round and pack an unpacked FP add/sub result into IEEE-754 binary32
//
// Ports:
//    clk, rst_n            clock (rising edge) and asynchronous active-low reset
//    in_valid / in_ready   input handshake; in_ready is high only while idle
//    sign_in               result sign
//    exp_in[9:0]           biased exponent, two's complement (-512..511)
//    mant_in[24:0]         {carry, hidden, fraction[22:0]}
//    grs_in[2:0]           {guard, round, sticky}
//    out_valid / out_ready output handshake; result and flags held until accepted
//    result_o[31:0]        packed {sign, exp[7:0], frac[22:0]}
//    ovf_o                 overflow to infinity
//    unf_o                 result denormal or zero, and inexact
//    inexact_o             any of G/R/S set at rounding
//
// Configuration macro NORM_PACK_RNE_EN: defined selects round-to-nearest-even,
// undefined selects truncation.
module norm_pack (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sign_in,
   input  logic [9:0]  exp_in,
   input  logic [24:0] mant_in,
   input  logic [2:0]  grs_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result_o,
   output logic        ovf_o,
   output logic        unf_o,
   output logic        inexact_o
);
   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
   state_t state_q, state_d;
   logic               sign_q, sign_d;
   // one extra bit so exponent increments near the top of the range cannot wrap
   logic signed [10:0] exp_q, exp_d;
   logic [24:0]        mant_q, mant_d;
   logic               g_q, g_d, r_q, r_d, s_q, s_d;
   logic [31:0]        res_q, res_d;
   logic               ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
   logic               shift_r, shift_l, far, inc, big, inx_w;
   logic [24:0]        sum;
   logic [23:0]        m_r;
   logic signed [10:0] e_r;

   assign shift_r = mant_q[24] | (exp_q < 11'sd1);
   assign shift_l = !mant_q[23] && (exp_q > 11'sd1) && (mant_q != 25'd0);
   assign far     = $signed(exp_in) < -10'sd24;
`ifdef NORM_PACK_RNE_EN
   assign inc = g_q & (r_q | s_q | mant_q[0]);
`else
   assign inc = 1'b0;
`endif
   // a round-up carry into bit 24 renormalizes in the same cycle; a denormal
   // rounding into bit 23 already sits at exp=1 and so becomes normal for free
   assign sum   = {1'b0, mant_q[23:0]} + {24'd0, inc};
   assign m_r   = sum[24] ? sum[24:1] : sum[23:0];
   assign e_r   = sum[24] ? exp_q + 11'sd1 : exp_q;
   assign big   = e_r >= 11'sd255;
   assign inx_w = g_q | r_q | s_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         mant_q  <= '0;
         g_q     <= 1'b0;
         r_q     <= 1'b0;
         s_q     <= 1'b0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         inx_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         mant_q  <= mant_d;
         g_q     <= g_d;
         r_q     <= r_d;
         s_q     <= s_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         inx_q   <= inx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = in_valid ? NORM : IDLE;
         NORM:  state_d = (shift_r | shift_l) ? NORM : ROUND;
         ROUND: state_d = DONE;
         DONE:  state_d = out_ready ? IDLE : DONE;
      endcase
   end

   always_comb begin
      in_ready  = state_q == IDLE;
      out_valid = state_q == DONE;
      result_o  = res_q;
      ovf_o     = ovf_q;
      unf_o     = unf_q;
      inexact_o = inx_q;
   end

   always_comb begin
      sign_d = sign_q;
      exp_d  = exp_q;
      mant_d = mant_q;
      g_d    = g_q;
      r_d    = r_q;
      s_d    = s_q;
      res_d  = res_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      inx_d  = inx_q;
      if (state_q == IDLE && in_valid) begin
         // far-underflow inputs collapse to a sticky-only zero; the exponent is
         // clamped so the right-shift walk to exp=1 stays within 25 steps
         sign_d = sign_in;
         exp_d  = far ? -11'sd24 : {exp_in[9], exp_in};
         mant_d = far ? 25'd0 : mant_in;
         g_d    = !far & grs_in[2];
         r_d    = !far & grs_in[1];
         s_d    = far | grs_in[0];
      end else if (state_q == NORM && shift_r) begin
         mant_d = mant_q >> 1;
         exp_d  = exp_q + 11'sd1;
         g_d    = mant_q[0];
         r_d    = g_q;
         s_d    = r_q | s_q;
      end else if (state_q == NORM && shift_l) begin
         mant_d = {mant_q[23:0], g_q};
         exp_d  = exp_q - 11'sd1;
         g_d    = r_q;
         r_d    = s_q;
      end else if (state_q == ROUND) begin
         res_d = big ? {sign_q, 8'hFF, 23'd0}
                     : {sign_q, m_r[23] ? e_r[7:0] : 8'd0, m_r[22:0]};
         ovf_d = big;
         inx_d = inx_w;
         unf_d = !big && !m_r[23] && inx_w;
      end
   end
endmodule

// File: tb/tb_norm_pack.sv
// tb_norm_pack: directed self-checking bench for norm_pack
module tb_norm_pack;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        sign_in = 1'b0;
   logic [9:0]  exp_in = '0;
   logic [24:0] mant_in = '0;
   logic [2:0]  grs_in = '0;
   logic        out_ready = 1'b1;
   logic        in_ready, out_valid, ovf_o, unf_o, inexact_o;
   logic [31:0] result_o;
   int          errors = 0;
   int          checks = 0;
   int          n;

   always #5 clk = ~clk;

   norm_pack dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in), .grs_in(grs_in),
      .out_valid(out_valid), .out_ready(out_ready), .result_o(result_o),
      .ovf_o(ovf_o), .unf_o(unf_o), .inexact_o(inexact_o)
   );

   // presents one operation for the accept edge and counts cycles until out_valid (bounded)
   task automatic send(input logic [9:0] e, input logic [24:0] m, input logic [2:0] g, output int cyc);
      exp_in = e; mant_in = m; grs_in = g; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 100) begin @(posedge clk); #1 cyc++; end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", result_o); end
      checks++; if ({ovf_o, unf_o, inexact_o} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ovf_o, unf_o, inexact_o}); end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_normal();
      send(10'd127, 25'h0C00000, 3'b000, n);
      checks++; if (n !== 3) begin errors++; $display("FAIL normal_latency got %0d want 3", n); end
      checks++; if (result_o !== 32'h3FC00000) begin errors++; $display("FAIL normal_result got %h want 3fc00000", result_o); end
      checks++; if ({ovf_o, unf_o, inexact_o} !== 3'b000) begin errors++; $display("FAIL normal_flags got %b want 000", {ovf_o, unf_o, inexact_o}); end
      drain();
   endtask

   task automatic test_carry();
      send(10'd127, 25'h1800000, 3'b000, n);
      checks++; if (n !== 4) begin errors++; $display("FAIL carry_latency got %0d want 4", n); end
      checks++; if (result_o !== 32'h40400000) begin errors++; $display("FAIL carry_result got %h want 40400000", result_o); end
      drain();
   endtask

   task automatic test_left();
      send(10'd150, 25'h0000001, 3'b000, n);
      checks++; if (n !== 26) begin errors++; $display("FAIL left_latency got %0d want 26", n); end
      checks++; if (result_o !== 32'h3F800000) begin errors++; $display("FAIL left_result got %h want 3f800000", result_o); end
      checks++; if ({ovf_o, unf_o, inexact_o} !== 3'b000) begin errors++; $display("FAIL left_flags got %b want 000", {ovf_o, unf_o, inexact_o}); end
      drain();
   endtask

   task automatic test_tie();
      logic [31:0] want;
`ifdef NORM_PACK_RNE_EN
      want = 32'h40000000;
`else
      want = 32'h3FFFFFFF;
`endif
      send(10'd127, 25'h0FFFFFF, 3'b100, n);
      checks++; if (n !== 3) begin errors++; $display("FAIL tie_latency got %0d want 3", n); end
      checks++; if (result_o !== want) begin errors++; $display("FAIL tie_result got %h want %h", result_o, want); end
      checks++; if ({ovf_o, unf_o, inexact_o} !== 3'b001) begin errors++; $display("FAIL tie_flags got %b want 001", {ovf_o, unf_o, inexact_o}); end
      drain();
   endtask

   task automatic test_overflow_bp();
      out_ready = 1'b0;
      send(10'd255, 25'h0800000, 3'b000, n);
      checks++; if (n !== 3) begin errors++; $display("FAIL ovf_latency got %0d want 3", n); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (result_o !== 32'h7F800000) begin errors++; $display("FAIL ovf_result[%0d] got %h want 7f800000", i, result_o); end
         checks++; if ({out_valid, in_ready, ovf_o} !== 3'b101) begin errors++; $display("FAIL ovf_hold[%0d] got valid/ready/ovf=%b want 101", i, {out_valid, in_ready, ovf_o}); end
         @(posedge clk); #1;
      end
      drain();
      checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL ovf_release got ready/valid=%b want 10", {in_ready, out_valid}); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      send(10'd127, 25'h0C00000, 3'b000, n);
      exp_in = 10'd127; mant_in = 25'h1800000; grs_in = 3'b000; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (result_o !== 32'h3FC00000) begin errors++; $display("FAIL b2b_hold got %h want 3fc00000", result_o); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL b2b_no_accept_in_done got ready/valid=%b want 10", {in_ready, out_valid}); end
      @(posedge clk); #1 in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got in_ready=%b want 0", in_ready); end
      n = 1;
      while (!out_valid && n < 100) begin @(posedge clk); #1 n++; end
      checks++; if (n !== 4) begin errors++; $display("FAIL b2b_latency got %0d want 4", n); end
      checks++; if (result_o !== 32'h40400000) begin errors++; $display("FAIL b2b_result got %h want 40400000", result_o); end
      drain();
   endtask

   task automatic test_denorm_reset();
      send(10'h3FF, 25'h0800000, 3'b000, n);
      checks++; if (n !== 5) begin errors++; $display("FAIL denorm_latency got %0d want 5", n); end
      checks++; if (result_o !== 32'h00200000) begin errors++; $display("FAIL denorm_result got %h want 00200000", result_o); end
      checks++; if ({ovf_o, unf_o, inexact_o} !== 3'b000) begin errors++; $display("FAIL denorm_flags got %b want 000", {ovf_o, unf_o, inexact_o}); end
      drain();
      exp_in = 10'd150; mant_in = 25'h0000001; grs_in = 3'b000; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL abort_immediate got ready/valid=%b want 10", {in_ready, out_valid}); end
      checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL abort_result got %h want 00000000", result_o); end
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_silent[%0d] got out_valid=%b want 0", i, out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_carry();
      test_left();
      test_tie();
      test_overflow_bp();
      test_back_to_back();
      test_denorm_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/norm_pack.md
# norm_pack

Result normalizer and packer for the FP add/sub datapath. Takes an unpacked significand that still carries its explicit hidden bit (plus carry bit and guard/round/sticky), renormalizes it iteratively, rounds, strips the hidden bit and emits a packed IEEE-754 single. It sits after the significand adder and before the register-file writeback, and is the inverse of the operand-unpack stage.

## Interface
- No parameters; fixed to binary32.
- `clk` in 1: clock; all state on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: unpacked result present.
- `in_ready` out 1: block idle, can accept.
- `sign_in` in 1: result sign.
- `exp_in` in 10: biased exponent, two's complement, range -512..511.
- `mant_in` in 25: [24] carry, [23] hidden, [22:0] fraction.
- `grs_in` in 3: guard, round, sticky.
- `out_valid` out 1: packed result valid.
- `out_ready` in 1: consumer accepts.
- `result_o` out 32: packed {sign, exp[7:0], frac[22:0]}.
- `ovf_o` out 1: overflow to infinity.
- `unf_o` out 1: result denormal or zero and inexact.
- `inexact_o` out 1: any G/R/S set at rounding.

## Operation
- FSM states: IDLE, NORM, ROUND, DONE. `in_ready` = (state==IDLE).
- IDLE: on `in_valid`, latch inputs and go to NORM. If `exp_in` < -24, load mant=0, G=R=0, S=1 instead.
- NORM: apply exactly one rule per cycle, in priority order:
  - mant[24]=1: shift right 1, exp+1; shifted-out bit goes to G, G goes to R, R|S goes to S.
  - exp<1: same right shift, exp+1.
  - mant[23]=0 and exp>1 and mant≠0: shift left 1, shifting G into bit 0; R goes to G, S goes to R; exp-1.
  - Otherwise: go to ROUND with no change that cycle.
- ROUND, RNE when enabled: increment mant[23:0] if G & (R | S | mant[0]).
  - On carry into bit 24: shift right, exp+1, same cycle.
  - A denormal that rounds into bit 23 becomes normal with exp=1.
- ROUND, pack:
  - Exponent field is exp[7:0] if mant[23]=1, else 0.
  - Fraction is mant[22:0]; the hidden bit is dropped.
  - If exp≥255 after rounding: result {sign, 8'hFF, 23'h0}, ovf=1.
  - mant=0 gives signed zero.
  - Result and flags are registered; go to DONE.
- DONE: `out_valid`=1; result and flags held stable until `out_ready`, then go to IDLE.
- An `in_valid` arriving during DONE is not accepted; the next accept is earliest the cycle after the DONE→IDLE edge.

## Timing
- Reset: state IDLE, `in_ready`=1, `out_valid`=0, `result_o`=0, all flags 0.
- Reset mid-operation aborts the in-flight result silently.
- Accept edge E: NORM at E+1; each shift adds 1 cycle; ROUND edge after the no-shift NORM cycle.
- `out_valid` is high 3+k cycles after E, where k = number of shifts.
- k ≤ 25. Latency is 3 to 28 cycles plus backpressure.
- No pipelining: one operation in flight.

## Configuration
- `NORM_PACK_RNE_EN` defined: round-to-nearest-even as above.
- `NORM_PACK_RNE_EN` undefined: truncate; ROUND never increments.
- Flags are computed identically with or without the macro, except that an overflow can only come from the input exponent.

## Test plan
- Normal 1.5: exp=127, mant=25'h0C00000, grs=0. Expect 32'h3FC00000, all flags 0, `out_valid` 3 cycles after accept.
- Carry: exp=127, mant=25'h1800000. Expect 32'h40400000 after 4 cycles.
- Left normalize: exp=150, mant=25'h0000001. Expect 32'h3F800000 after 26 cycles.
- Tie round: exp=127, mant=25'h0FFFFFF, grs=3'b100.
  - With macro: 32'h40000000, inexact=1.
  - Without macro: 32'h3FFFFFFF, inexact=1.
- Overflow and backpressure: exp=255, mant=25'h0800000, `out_ready` held 0 for 5 cycles. Expect 32'h7F800000 and ovf=1 held stable throughout; `in_ready`=0 until release.
- Denormal: exp=10'h3FF (-1), mant=25'h0800000. Expect 32'h00200000 with unf=0 after 5 cycles. Assert `rst_n` in the next op's NORM: `out_valid` stays 0 and `in_ready`=1 immediately.
